// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one unified memory port between the instruction-fetch and data
//   (load/store) ports of the rv32i datapath. One transaction at a time,
//   round-robin on simultaneous requests, combinational stall to the core.
//
// Ports
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   imem_req/addr -> rdata/ready  fetch port (ready is a one-cycle pulse)
//   dmem_req/we/addr/wdata
//                 -> rdata/ready  data port (ready is a one-cycle pulse)
//   mem_valid/we/addr/wdata       request to the single-port memory
//   mem_rdata/mem_ready           memory response (sampled while mem_valid=1)
//   stall                         combinational: a port is waiting for ready
//   err                           one-cycle abort flag, coincident with *_ready
//
// Build option
//   ARB_TIMEOUT_EN  when defined, a transaction still in BUSY after
//                   TimeoutCycles cycles is aborted with err=1 and rdata=0.
//                   When undefined, BUSY waits indefinitely and err is 0.

module mem_port_arbiter #(
   parameter int unsigned AddrWidth     = 32,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned TimeoutCycles = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 imem_req,
   input  logic [AddrWidth-1:0] imem_addr,
   output logic [DataWidth-1:0] imem_rdata,
   output logic                 imem_ready,
   input  logic                 dmem_req,
   input  logic                 dmem_we,
   input  logic [AddrWidth-1:0] dmem_addr,
   input  logic [DataWidth-1:0] dmem_wdata,
   output logic [DataWidth-1:0] dmem_rdata,
   output logic                 dmem_ready,
   output logic                 mem_valid,
   output logic                 mem_we,
   output logic [AddrWidth-1:0] mem_addr,
   output logic [DataWidth-1:0] mem_wdata,
   input  logic [DataWidth-1:0] mem_rdata,
   input  logic                 mem_ready,
   output logic                 stall,
   output logic                 err
);

   // Reject a zero timeout at elaboration.
   if (TimeoutCycles == 0) begin : g_param_check
      $error("mem_port_arbiter: TimeoutCycles must be >= 1");
   end

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

   state_t               r_state;
   logic                 r_last_d;     // 1: last grant went to the data port
   logic                 r_gnt_d;      // 1: current transaction belongs to the data port
   logic                 r_mem_valid;
   logic                 r_mem_we;
   logic [AddrWidth-1:0] r_mem_addr;
   logic [DataWidth-1:0] r_mem_wdata;
   logic                 r_imem_ready;
   logic                 r_dmem_ready;
   logic [DataWidth-1:0] r_imem_rdata;
   logic [DataWidth-1:0] r_dmem_rdata;
   logic                 w_grant_d;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
   logic [CntWidth-1:0]  r_cnt;
   logic                 r_err;
`endif

   // Data wins when alone, or on a tie when fetch was granted last.
   assign w_grant_d = dmem_req & (~imem_req | ~r_last_d);

   // Main FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_last_d     <= 1'b0;
         r_gnt_d      <= 1'b0;
         r_mem_valid  <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_imem_ready <= 1'b0;
         r_dmem_ready <= 1'b0;
         r_imem_rdata <= '0;
         r_dmem_rdata <= '0;
`ifdef ARB_TIMEOUT_EN
         r_cnt        <= '0;
         r_err        <= 1'b0;
`endif
      end else begin
         r_imem_ready <= 1'b0;
         r_dmem_ready <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         r_err        <= 1'b0;
`endif
         case (r_state)
            ST_IDLE: begin
               if (imem_req | dmem_req) begin
                  r_state     <= ST_BUSY;
                  r_mem_valid <= 1'b1;
                  r_gnt_d     <= w_grant_d;
                  r_last_d    <= w_grant_d;
`ifdef ARB_TIMEOUT_EN
                  r_cnt       <= '0;
`endif
                  if (w_grant_d) begin
                     r_mem_we    <= dmem_we;
                     r_mem_addr  <= dmem_addr;
                     r_mem_wdata <= dmem_wdata;
                  end else begin
                     // Fetches are always reads; no store data to carry.
                     r_mem_we    <= 1'b0;
                     r_mem_addr  <= imem_addr;
                     r_mem_wdata <= '0;
                  end
               end
            end
            ST_BUSY: begin
               if (mem_ready) begin
                  r_state     <= ST_RESP;
                  r_mem_valid <= 1'b0;
                  if (r_gnt_d) begin
                     r_dmem_ready <= 1'b1;
                     r_dmem_rdata <= mem_rdata;
                  end else begin
                     r_imem_ready <= 1'b1;
                     r_imem_rdata <= mem_rdata;
                  end
               end
`ifdef ARB_TIMEOUT_EN
               // Last allowed BUSY cycle without mem_ready: abort.
               else if (r_cnt == CntWidth'(TimeoutCycles - 1)) begin
                  r_state     <= ST_RESP;
                  r_mem_valid <= 1'b0;
                  r_err       <= 1'b1;
                  if (r_gnt_d) begin
                     r_dmem_ready <= 1'b1;
                     r_dmem_rdata <= '0;
                  end else begin
                     r_imem_ready <= 1'b1;
                     r_imem_rdata <= '0;
                  end
               end else begin
                  r_cnt <= r_cnt + CntWidth'(1);
               end
`endif
            end
            ST_RESP: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign mem_valid  = r_mem_valid;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign imem_ready = r_imem_ready;
   assign dmem_ready = r_dmem_ready;
   assign imem_rdata = r_imem_rdata;
   assign dmem_rdata = r_dmem_rdata;

   // Freeze the core while any requester is still waiting.
   assign stall = (imem_req & ~r_imem_ready) | (dmem_req & ~r_dmem_ready);

`ifdef ARB_TIMEOUT_EN
   assign err = r_err;
`else
   assign err = 1'b0;
`endif

endmodule
